ft245_bridge: RTL
=================

FT245_BRIDGE -- requirements
Module: ft245_bridge

Interface
REQ-001 SHALL have parameter RD_PULSE, default 4, ft_rd_n low time in clk cycles (legal range 1..15).
REQ-002 SHALL have parameter WR_PULSE, default 3, ft_wr high time in clk cycles (legal range 1..15).
REQ-003 SHALL have parameter TIMEOUT_CYC, default 1024, wait-state limit in clk cycles (used only with REQ-024).
REQ-004 SHALL have port clk, input, 1, single system clock; all logic is on the rising edge.
REQ-005 SHALL have port rst, input, 1; reset is asynchronous and active-high.
REQ-006 SHALL have port req_rx, input, 1, decoded serial-in read cycle, level, held until the CPU ends the bus cycle.
REQ-007 SHALL have port req_tx, input, 1, decoded serial-out write cycle, level.
REQ-008 SHALL have port req_st, input, 1, decoded serial-status read cycle, level.
REQ-009 SHALL have ports cpu_din (input, 8) and cpu_dout (output, 8): CPU write data and CPU read data.
REQ-010 SHALL have port dtack_n, output, 1, bus-cycle acknowledge, active-low.
REQ-011 SHALL have ports ft_rxf_n and ft_txe_n, inputs, 1 each, asynchronous FIFO flags.
REQ-012 SHALL have ports ft_rd_n (output, 1), ft_wr (output, 1), ft_din (input, 8), ft_dout (output, 8), and ft_oe (output, 1; high means drive ft_dout onto the FIFO bus).

Function
REQ-013 SHALL pass ft_rxf_n and ft_txe_n through 2-flop synchronisers; all decisions SHALL use the synchronised rxf_s and txe_s.
REQ-014 SHALL implement states IDLE, WAIT_RX, RD_STROBE, WAIT_TX, WR_SETUP, WR_STROBE, WR_HOLD, ACK.
REQ-015 IDLE SHALL accept requests with priority req_st > req_rx > req_tx; simultaneous requests SHALL serve only the highest-priority one.
REQ-016 A status request SHALL go IDLE->ACK; cpu_dout = {tmo, 5'b0, ~txe_s, ~rxf_s}, sampled on accept; dtack_n SHALL be low 1 cycle after the request is seen.
REQ-017 A receive request SHALL go IDLE->WAIT_RX; WAIT_RX->RD_STROBE when rxf_s==0; ft_rd_n SHALL be low for exactly RD_PULSE cycles; ft_din SHALL be registered into cpu_dout on the last strobe edge; then ACK.
REQ-018 A transmit request SHALL latch cpu_din on accept and go to WAIT_TX; WAIT_TX->WR_SETUP when txe_s==0.
REQ-019 On a transmit, ft_oe SHALL be high from WR_SETUP through WR_HOLD, inclusive; ft_wr SHALL be high for exactly WR_PULSE cycles (WR_STROBE); WR_HOLD SHALL last 1 cycle with ft_wr low; then ACK.
REQ-020 ACK SHALL hold dtack_n low until all of req_st, req_rx and req_tx are low, then go to IDLE; a request that stays high SHALL NOT start a second transfer.
REQ-021 cpu_dout SHALL hold its last value outside ACK; ft_dout SHALL hold the latched byte until the next accept.
REQ-022 Requests that drop before ACK (aborted CPU cycle) SHALL NOT cancel an active strobe; the strobe SHALL complete and ACK SHALL exit immediately.

Reset
REQ-023 On rst, at any time including mid-strobe, the block SHALL go to IDLE with: dtack_n=1, ft_rd_n=1, ft_wr=0, ft_oe=0, cpu_dout=0, ft_dout=0, tmo=0, and synchronisers = 1.

Configuration
REQ-024 With FT245_TIMEOUT_EN defined, WAIT_RX and WAIT_TX SHALL count cycles; on reaching TIMEOUT_CYC the block SHALL go to ACK with the sticky bit tmo set. A timed-out read SHALL return cpu_dout=8'hFF; a timed-out write SHALL drop its byte (no ft_wr pulse).
REQ-025 tmo SHALL clear on the ACK of a status read. Without FT245_TIMEOUT_EN, waits SHALL be unbounded, tmo SHALL be constant 0, and no counter SHALL be synthesised.

Structure
REQ-026 Package ft245_pkg SHALL hold the state enum, status bit indices (RXA=0, TXA=1, TMO=7) and the timeout read value 8'hFF.
REQ-027 The 2-flop synchroniser SHALL be sub-module ft245_sync, instantiated twice.

Verification
REQ-028 ft_rxf_n low for 10 cycles, ft_din=8'h5A, req_rx at cycle 0 -> ft_rd_n low cycles 2-5, dtack_n low at cycle 6, cpu_dout=8'h5A.
REQ-029 ft_txe_n low, cpu_din=8'hC3, req_tx at cycle 0 -> ft_oe high cycles 2-6, ft_wr high cycles 3-5, ft_dout=8'hC3, dtack_n low at cycle 7.
REQ-030 ft_rxf_n=0, ft_txe_n=1, req_st -> cpu_dout=8'h01, dtack_n low at cycle 1, released 1 cycle after req_st falls.
REQ-031 req_st and req_rx together -> status served only; no ft_rd_n pulse.
REQ-032 rst asserted in the middle of RD_STROBE -> ft_rd_n=1 and dtack_n=1 immediately; IDLE after release.
REQ-033 With FT245_TIMEOUT_EN, ft_rxf_n held high and req_rx -> ACK after 1024 wait cycles, cpu_dout=8'hFF; the next status read shows bit7=1, and the read after that shows bit7=0.

Source files
------------

// File: rtl/ft245_pkg.sv
// Shared types and constants for the FT245 FIFO bridge: FSM states, status
// byte layout and the value returned by a timed-out read.
package ft245_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StWaitRx,
    StRdStrobe,
    StWaitTx,
    StWrSetup,
    StWrStrobe,
    StWrHold,
    StAck
  } state_e;

  localparam int unsigned RXA = 0;
  localparam int unsigned TXA = 1;
  localparam int unsigned TMO = 7;

  localparam logic [7:0] TMO_RD_VAL = 8'hFF;

  // Flags are active-low at the pins; the status byte reports them active-high.
  function automatic logic [7:0] status_byte(input logic tmo, input logic txe_s,
                                             input logic rxf_s);
    logic [7:0] s;
    s      = '0;
    s[TMO] = tmo;
    s[TXA] = ~txe_s;
    s[RXA] = ~rxf_s;
    return s;
  endfunction

endpackage

// File: rtl/ft245_sync.sv
// Two-flop synchroniser for an asynchronous FIFO flag; resets to 1 (flag inactive).
module ft245_sync (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta_q, sync_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/ft245_bridge.sv
// CPU bus to FT245 FIFO bridge: status, receive and transmit cycles with dtack_n handshake.
// Define FT245_TIMEOUT_EN to bound the FIFO flag waits and enable the sticky tmo status bit.
module ft245_bridge
  import ft245_pkg::*;
#(
  parameter int unsigned RD_PULSE    = 4,
  parameter int unsigned WR_PULSE    = 3,
  parameter int unsigned TIMEOUT_CYC = 1024
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_rx,
  input  logic       req_tx,
  input  logic       req_st,
  input  logic [7:0] cpu_din,
  output logic [7:0] cpu_dout,
  output logic       dtack_n,
  input  logic       ft_rxf_n,
  input  logic       ft_txe_n,
  output logic       ft_rd_n,
  output logic       ft_wr,
  input  logic [7:0] ft_din,
  output logic [7:0] ft_dout,
  output logic       ft_oe
);

  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [7:0] cpu_dout_q, cpu_dout_d;
  logic [7:0] ft_dout_q, ft_dout_d;
  logic       dtack_n_q, ft_rd_n_q, ft_wr_q, ft_oe_q;
  logic       rxf_s, txe_s;
  logic       tmo, tmo_d;
  logic       wait_expired;

  ft245_sync u_sync_rxf (
    .clk (clk),
    .rst (rst),
    .d   (ft_rxf_n),
    .q   (rxf_s)
  );

  ft245_sync u_sync_txe (
    .clk (clk),
    .rst (rst),
    .d   (ft_txe_n),
    .q   (txe_s)
  );

`ifdef FT245_TIMEOUT_EN
  localparam int unsigned TmoW = $clog2(TIMEOUT_CYC + 1);

  logic [TmoW-1:0] wcnt_q;
  logic            tmo_q;

  // Counter runs only while parked in a wait state; IDLE always precedes a wait.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wcnt_q <= '0;
      tmo_q  <= 1'b0;
    end else begin
      if (state_q inside {StWaitRx, StWaitTx}) begin
        wcnt_q <= wcnt_q + 1'b1;
      end else begin
        wcnt_q <= '0;
      end
      tmo_q <= tmo_d;
    end
  end

  assign wait_expired = (wcnt_q == TmoW'(TIMEOUT_CYC - 1));
  assign tmo          = tmo_q;
`else
  logic unused_cfg;

  assign wait_expired = 1'b0;
  assign tmo          = 1'b0;
  assign unused_cfg   = tmo_d ^ TIMEOUT_CYC[0];
`endif

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    cpu_dout_d = cpu_dout_q;
    ft_dout_d  = ft_dout_q;
    tmo_d      = tmo;

    unique case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (req_st) begin
          // Reading status reports and clears the sticky timeout bit.
          cpu_dout_d = status_byte(tmo, txe_s, rxf_s);
          tmo_d      = 1'b0;
          state_d    = StAck;
        end else if (req_rx) begin
          state_d = StWaitRx;
        end else if (req_tx) begin
          ft_dout_d = cpu_din;
          state_d   = StWaitTx;
        end
      end
      StWaitRx: begin
        cnt_d = '0;
        if (!rxf_s) begin
          state_d = StRdStrobe;
        end else if (wait_expired) begin
          cpu_dout_d = TMO_RD_VAL;
          tmo_d      = 1'b1;
          state_d    = StAck;
        end
      end
      StRdStrobe: begin
        if (cnt_q == 4'(RD_PULSE - 1)) begin
          cpu_dout_d = ft_din;
          state_d    = StAck;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      StWaitTx: begin
        cnt_d = '0;
        if (!txe_s) begin
          state_d = StWrSetup;
        end else if (wait_expired) begin
          tmo_d   = 1'b1;
          state_d = StAck;
        end
      end
      StWrSetup: begin
        cnt_d   = '0;
        state_d = StWrStrobe;
      end
      StWrStrobe: begin
        if (cnt_q == 4'(WR_PULSE - 1)) begin
          state_d = StWrHold;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      StWrHold: begin
        state_d = StAck;
      end
      StAck: begin
        if (!(req_st || req_rx || req_tx)) begin
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Strobes and acknowledge are decoded from the next state and registered,
  // so the pins are glitch-free and change on the same edge as the state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      cpu_dout_q <= '0;
      ft_dout_q  <= '0;
      dtack_n_q  <= 1'b1;
      ft_rd_n_q  <= 1'b1;
      ft_wr_q    <= 1'b0;
      ft_oe_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      cpu_dout_q <= cpu_dout_d;
      ft_dout_q  <= ft_dout_d;
      dtack_n_q  <= (state_d != StAck);
      ft_rd_n_q  <= (state_d != StRdStrobe);
      ft_wr_q    <= (state_d == StWrStrobe);
      ft_oe_q    <= (state_d inside {StWrSetup, StWrStrobe, StWrHold});
    end
  end

  assign cpu_dout = cpu_dout_q;
  assign ft_dout  = ft_dout_q;
  assign dtack_n  = dtack_n_q;
  assign ft_rd_n  = ft_rd_n_q;
  assign ft_wr    = ft_wr_q;
  assign ft_oe    = ft_oe_q;

endmodule
